// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer.
// Contents: the debounce FSM state encoding and the default parameter values
// used by input_debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } db_state_t;

    localparam int   DEF_SYNC_STAGES   = 2;
    localparam int   DEF_STABLE_CYCLES = 4;
    localparam int   DEF_GLITCH_W      = 8;
    localparam logic DEF_RESET_VAL     = 1'b0;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// sync_chain: multi-flop synchroniser that brings an asynchronous input into
// the clk domain. It is generic so other asynchronous inputs can reuse it.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; loads every flop with RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output (last flop of the chain)
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    // sync_reg[0] captures d; each later stage copies the previous one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: turns a bouncy asynchronous input into a clean level that
// only follows the input after it has been stable for STABLE_CYCLES cycles.
// Aborted qualifications are counted in a saturating glitch counter.
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   raw_in       - asynchronous external input, may bounce
//   glitch_clr   - synchronous clear of glitch_count (wins over an increment)
//   debounced    - registered filtered level
//   settling     - high while a candidate transition is being qualified
//   glitch_count - saturating count of rejected transitions
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   GLITCH_W      = DEF_GLITCH_W,
    parameter logic RESET_VAL     = DEF_RESET_VAL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                debounced,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // The qualifying cycle is the one where cnt+1 reaches STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam db_state_t        RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

    logic                s;
    logic                reject;
    db_state_t           state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                debounced_reg;
    logic                settling_reg;
    logic [GLITCH_W-1:0] glitch_reg;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    // A candidate is rejected when the input falls back to the stable level
    // before qualification completes.
    assign reject = ((state_reg == QUAL_HI) && !s) || ((state_reg == QUAL_LO) && s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RESET_STATE;
            cnt_reg       <= '0;
            debounced_reg <= RESET_VAL;
            settling_reg  <= 1'b0;
        end else begin
            case (state_reg)
                STABLE_LO: begin
                    if (s) begin
                        if (STABLE_CYCLES == 1) begin
                            debounced_reg <= 1'b1;
                            state_reg     <= STABLE_HI;
                        end else begin
                            state_reg    <= QUAL_HI;
                            cnt_reg      <= CNT_ONE;
                            settling_reg <= 1'b1;
                        end
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_reg    <= STABLE_LO;
                        cnt_reg      <= '0;
                        settling_reg <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        debounced_reg <= 1'b1;
                        state_reg     <= STABLE_HI;
                        cnt_reg       <= '0;
                        settling_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        if (STABLE_CYCLES == 1) begin
                            debounced_reg <= 1'b0;
                            state_reg     <= STABLE_LO;
                        end else begin
                            state_reg    <= QUAL_LO;
                            cnt_reg      <= CNT_ONE;
                            settling_reg <= 1'b1;
                        end
                    end
                end
                QUAL_LO: begin
                    if (s) begin
                        state_reg    <= STABLE_HI;
                        cnt_reg      <= '0;
                        settling_reg <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        debounced_reg <= 1'b0;
                        state_reg     <= STABLE_LO;
                        cnt_reg       <= '0;
                        settling_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg     <= RESET_STATE;
                    cnt_reg       <= '0;
                    debounced_reg <= RESET_VAL;
                    settling_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Glitch counter: clear has priority, increments stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset || glitch_clr) begin
            glitch_reg <= '0;
        end else if (reject && (glitch_reg != '1)) begin
            glitch_reg <= glitch_reg + 1'b1;
        end
    end

    assign debounced    = debounced_reg;
    assign settling     = settling_reg;
    assign glitch_count = glitch_reg;

endmodule
